fnd_bin2bcd_seq: RTL

Sequential binary-to-BCD converter using shift-add-3 (double dabble). It sits directly upstream of the FND display digit mux inside the FND controller and replaces the combinational divide/modulo digit split. It accepts a binary value from the APB data register path, produces packed BCD digits over BIN_W+1 cycles, and holds the result for the display scan.

---
 rtl/fnd_pkg.sv | 35 +++
 rtl/fnd_dabble_digit.sv | 10 +
 rtl/fnd_bin2bcd_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND binary-to-BCD converter.
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam int FND_DIGITS  = 4;
  localparam int FND_BIN_W   = 14;
  localparam int FND_BCD_MAX = 9999;

  // Number of decimal digits needed to hold 2^w-1 without loss.
  function automatic int fnd_dec_digits(input int unsigned w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

  // 10^d as a 64-bit value.
  function automatic longint unsigned fnd_pow10(input int d);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/fnd_dabble_digit.sv
// Double-dabble nibble corrector: adds 3 when the BCD digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module fnd_dabble_digit (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/fnd_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding the FND digit mux.
// One request is converted over BIN_W shift cycles; results are held until
// the next conversion completes. Values above 10^DIGITS-1 saturate to all 9s.
// Optional: define FND_LZB_EN to build the leading-zero blanking mask.
module fnd_bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int BIN_W  = FND_BIN_W,
  parameter int DIGITS = FND_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  // Scratch must be wide enough for the full binary range so the shift is
  // lossless even when the exported digits saturate.
  localparam int              DEC_NIB = fnd_dec_digits(BIN_W);
  localparam int              SCR_NIB = (DEC_NIB > DIGITS) ? DEC_NIB : DIGITS;
  localparam int              SCR_W   = 4 * SCR_NIB;
  localparam int              CNT_W   = $clog2(BIN_W + 1);
  localparam longint unsigned BCD_MAX = fnd_pow10(DIGITS) - 64'd1;

  bcd_state_t             state_q, state_d;
  logic [BIN_W-1:0]       shift_q, shift_d;
  logic [SCR_W-1:0]       scr_q, scr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_cap_q, ovf_cap_d;
  logic                   out_valid_q, out_valid_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic                   overflow_q, overflow_d;
  logic [DIGITS-1:0]      blank_q, blank_d;

  logic [SCR_W-1:0]       scr_adj;
  logic [SCR_W+BIN_W-1:0] cat_shl;
  logic [4*DIGITS-1:0]    bcd_res;
  logic [DIGITS-1:0]      blank_calc;

  function automatic logic [4*DIGITS-1:0] sat_bcd(input logic                ovf,
                                                  input logic [4*DIGITS-1:0] v);
    return ovf ? {DIGITS{4'h9}} : v;
  endfunction

  // Add-3 correction on every scratch nibble before each shift.
  for (genvar g = 0; g < SCR_NIB; g++) begin : g_nib
    fnd_dabble_digit u_dig (
      .nib_i (scr_q[4*g +: 4]),
      .nib_o (scr_adj[4*g +: 4])
    );
  end

  assign cat_shl = {scr_adj, shift_q} << 1;
  assign bcd_res = scr_q[4*DIGITS-1:0];

`ifdef FND_LZB_EN
  // Leading-zero mask: digit i>0 blanks when it and all higher digits are zero.
  always_comb begin : lzb_calc
    logic zero_above;
    blank_calc = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above    = zero_above && (bcd_res[4*i +: 4] == 4'd0);
      blank_calc[i] = zero_above;
    end
    if (ovf_cap_q) blank_calc = '0;
  end
`else
  assign blank_calc = '0;
`endif

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    scr_d       = scr_q;
    cnt_d       = cnt_q;
    ovf_cap_d   = ovf_cap_q;
    out_valid_d = 1'b0;
    bcd_d       = bcd_q;
    overflow_d  = overflow_q;
    blank_d     = blank_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = bin;
          scr_d     = '0;
          cnt_d     = '0;
          ovf_cap_d = (64'(bin) > BCD_MAX);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scr_d   = cat_shl[SCR_W+BIN_W-1 -: SCR_W];
        shift_d = cat_shl[BIN_W-1:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        // Result registers and the valid pulse update together as DONE closes.
        out_valid_d = 1'b1;
        bcd_d       = sat_bcd(ovf_cap_q, bcd_res);
        overflow_d  = ovf_cap_q;
        blank_d     = blank_calc;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      scr_q       <= '0;
      cnt_q       <= '0;
      ovf_cap_q   <= 1'b0;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
      blank_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      scr_q       <= scr_d;
      cnt_q       <= cnt_d;
      ovf_cap_q   <= ovf_cap_d;
      out_valid_q <= out_valid_d;
      bcd_q       <= bcd_d;
      overflow_q  <= overflow_d;
      blank_q     <= blank_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign overflow  = overflow_q;
  assign blank     = blank_q;

endmodule
